// File: rtl/vm_pkg.sv
// Shared types and default widths for the vector-machine reduction stages.
package vm_pkg;

    localparam int DEF_WIDTH     = 24;
    localparam int DEF_ACC_WIDTH = 48;
    localparam int DEF_LEN_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_e;

endpackage

// File: rtl/pair_adder.sv
// Combinational sum of two unsigned lanes with a carry bit, so no information
// is lost before the caller widens it further.
module pair_adder
    import vm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH:0]   sum_o
);

    assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/sum_sq_accum.sv
// Accumulates squared lane pairs over a programmable-length vector and
// presents the wrapped sum plus a sticky overflow flag on an output handshake.
module sum_sq_accum
    import vm_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] vec_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     square_1,
    input  logic [WIDTH-1:0]     square_2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] sum_out,
    output logic                 overflow,
    output logic                 busy
);

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;

    logic [WIDTH:0]       pair_sum;
    logic [ACC_WIDTH:0]   acc_sum;
    logic                 beat;

    pair_adder #(.WIDTH(WIDTH)) u_pair_adder (
        .a_i   (square_1),
        .b_i   (square_2),
        .sum_o (pair_sum)
    );

    // One extra bit on top of the accumulator catches the wrap for overflow.
    assign acc_sum = {1'b0, acc_q} + {{(ACC_WIDTH-WIDTH){1'b0}}, pair_sum};
    assign beat    = in_valid && in_ready;

    // NOTE: reset is sampled on the clock edge, and all state uses <= so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (vec_len == '0) ? DONE : ACCUM;
            ACCUM:   if (beat && cnt_q == LEN_WIDTH'(1)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE:    busy      = 1'b0;
            ACCUM:   in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: busy      = 1'b0;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (state_q == IDLE && start) begin
            cnt_d = vec_len;
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (beat) begin
            cnt_d = cnt_q - LEN_WIDTH'(1);
            acc_d = acc_sum[ACC_WIDTH-1:0];
            ovf_d = ovf_q | acc_sum[ACC_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign sum_out  = acc_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_sum_sq_accum.sv
// Randomized scoreboard bench for sum_sq_accum, plus a narrow-accumulator
// instance for the wrap/overflow behaviour.
module tb_sum_sq_accum;
    import vm_pkg::*;

    typedef struct {
        logic [47:0] sum;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        start, in_valid, out_ready;
    logic [7:0]  vec_len;
    logic [23:0] sq1, sq2;
    logic        in_ready, out_valid, overflow, busy;
    logic [47:0] sum_out;

    logic        o_start, o_in_valid, o_out_ready;
    logic [7:0]  o_vec_len;
    logic [23:0] o_sq1, o_sq2;
    logic        o_in_ready, o_out_valid, o_overflow, o_busy;
    logic [24:0] o_sum_out;

    sum_sq_accum dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
        .in_valid(in_valid), .in_ready(in_ready), .square_1(sq1), .square_2(sq2),
        .out_valid(out_valid), .out_ready(out_ready), .sum_out(sum_out),
        .overflow(overflow), .busy(busy)
    );

    sum_sq_accum #(.ACC_WIDTH(25)) dut_ovf (
        .clk(clk), .rst_n(rst_n), .start(o_start), .vec_len(o_vec_len),
        .in_valid(o_in_valid), .in_ready(o_in_ready), .square_1(o_sq1), .square_2(o_sq2),
        .out_valid(o_out_valid), .out_ready(o_out_ready), .sum_out(o_sum_out),
        .overflow(o_overflow), .busy(o_busy)
    );

    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];
    logic [23:0] pa[$], pb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: total of all squares in the vector, reduced modulo 2^aw.
    function automatic exp_t model(input int aw);
        exp_t            e;
        longint unsigned total = 0;
        longint unsigned modv  = 64'd1 << aw;
        foreach (pa[i]) total += longint'(pa[i]) + longint'(pb[i]);
        e.sum = 48'(total % modv);
        e.ovf = (total >= modv);
        return e;
    endfunction

    // Monitor: every output handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 64'(sum_out), 64'hDEAD);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sum_out", 64'(sum_out), 64'(e.sum));
                check("overflow", 64'(overflow), 64'(e.ovf));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Drives the vector held in pa/pb; gaps may carry ignored start pulses.
    task automatic send_vector(input int hold, input int gap_max);
        int   len;
        exp_t e;
        len = pa.size();
        e   = model(48);
        sb_q.push_back(e);
        start   = 1'b1;
        vec_len = 8'(len);
        tick();
        start = 1'b0;
        check("in_ready_after_start", 64'(in_ready), 64'(len != 0));
        check("out_valid_after_start", 64'(out_valid), 64'(len == 0));
        for (int i = 0; i < len; i++) begin
            int gaps;
            gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            repeat (gaps) begin
                in_valid = 1'b0;
                start    = 1'($urandom);
                vec_len  = 8'($urandom);
                tick();
            end
            start    = 1'b0;
            in_valid = 1'b1;
            sq1      = pa[i];
            sq2      = pb[i];
            tick();
            in_valid = 1'b0;
        end
        check("out_valid_done", 64'(out_valid), 64'd1);
        check("in_ready_done", 64'(in_ready), 64'd0);
        repeat (hold) begin
            start    = 1'b1;
            vec_len  = 8'd5;
            in_valid = 1'b1;
            sq1      = 24'($urandom);
            sq2      = 24'($urandom);
            tick();
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_sum_out", 64'(sum_out), 64'(e.sum));
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_out_valid", 64'(out_valid), 64'd0);
    endtask

    task automatic load_random(input int len);
        pa.delete();
        pb.delete();
        for (int i = 0; i < len; i++) begin
            pa.push_back(24'($urandom));
            pb.push_back(24'($urandom));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; vec_len = '0; in_valid = 1'b0; out_ready = 1'b0; sq1 = '0; sq2 = '0;
        o_start = 1'b0; o_vec_len = '0; o_in_valid = 1'b0; o_out_ready = 1'b0;
        o_sq1 = '0; o_sq2 = '0;
        repeat (3) tick();
        check("rst_sum_out", 64'(sum_out), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        tick();

        // Three-beat vector: squares of (1,2), (10,30), (40,77) -> 8534.
        pa = '{24'd1, 24'd100, 24'd1600};
        pb = '{24'd4, 24'd900, 24'd5929};
        check("model_8534", 64'(model(48).sum), 64'd8534);
        send_vector(0, 0);

        // Zero-length vector.
        pa.delete();
        pb.delete();
        send_vector(0, 0);

        // Same data with gaps and a 5-cycle backpressure hold must match.
        load_random(6);
        send_vector(0, 0);
        send_vector(5, 3);

        // Reset mid-vector after 1 of 3 beats.
        start = 1'b1; vec_len = 8'd3;
        tick();
        start = 1'b0; in_valid = 1'b1; sq1 = 24'd5; sq2 = 24'd6;
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        check("midrst_sum_out", 64'(sum_out), 64'd0);
        check("midrst_overflow", 64'(overflow), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        // in_valid in IDLE is not accepted.
        repeat (3) begin
            in_valid = 1'b1;
            sq1      = 24'($urandom);
            sq2      = 24'($urandom);
            tick();
            check("idle_in_ready", 64'(in_ready), 64'd0);
            check("idle_busy_valid", 64'(busy), 64'd0);
        end
        in_valid = 1'b0;

        pa = '{24'd7};
        pb = '{24'd9};
        check("model_16", 64'(model(48).sum), 64'd16);
        send_vector(0, 0);

        // Random vectors with gaps, ignored starts and backpressure.
        for (int v = 0; v < 12; v++) begin
            load_random(int'($urandom_range(0, 12)));
            send_vector(int'($urandom_range(0, 3)), 2);
        end

        // Narrow accumulator: two beats of (0xFFFFFF, 0xFFFFFF) wrap once.
        o_start = 1'b1; o_vec_len = 8'd2;
        tick();
        o_start = 1'b0; o_in_valid = 1'b1; o_sq1 = 24'hFFFFFF; o_sq2 = 24'hFFFFFF;
        tick();
        check("ovf_first_beat", 64'(o_overflow), 64'd0);
        tick();
        o_in_valid = 1'b0;
        check("ovf_out_valid", 64'(o_out_valid), 64'd1);
        check("ovf_sum_out", 64'(o_sum_out), 64'h1FFFFFC);
        check("ovf_flag", 64'(o_overflow), 64'd1);
        o_out_ready = 1'b1;
        tick();
        o_out_ready = 1'b0;
        o_start = 1'b1; o_vec_len = 8'd1;
        tick();
        o_start = 1'b0;
        check("ovf_cleared", 64'(o_overflow), 64'd0);
        o_in_valid = 1'b1; o_sq1 = 24'd1; o_sq2 = 24'd2;
        tick();
        o_in_valid = 1'b0;
        check("ovf_small_sum", 64'(o_sum_out), 64'd3);
        check("ovf_small_flag", 64'(o_overflow), 64'd0);
        o_out_ready = 1'b1;
        tick();
        o_out_ready = 1'b0;

        repeat (3) tick();
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
